// File: rtl/mmu_pkg.sv
// Shared encodings and width constants for the page-table-walker memory arbiter.
package mmu_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_WAIT = 2'd1;
  localparam logic [1:0] ARB_RESP = 2'd2;

  localparam int unsigned PTW_ADDR_WIDTH = 32;
  localparam int unsigned PTW_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle = ARB_IDLE,
    StWait = ARB_WAIT,
    StResp = ARB_RESP
  } arb_state_e;

endpackage

// File: rtl/ptw_rr_arbiter.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
module ptw_rr_arbiter (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    unique case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_owner;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/ptw_mem_arbiter.sv
// Shares one page-table memory read port between the I-side and D-side walkers,
// with one outstanding transaction and a timeout that returns an error response.
module ptw_mem_arbiter
  import mmu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = PTW_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = PTW_DATA_WIDTH,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic                  resp0,
  output logic                  resp1,
  output logic [DATA_WIDTH-1:0] data0,
  output logic [DATA_WIDTH-1:0] data1,
  output logic                  err0,
  output logic                  err1,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_resp,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  busy,
  output logic                  owner,
  output logic                  timeout_pulse
);

  localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax   = '1;
  localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT);

  arb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic                  owner_q, owner_d;
  logic                  last_owner_q, last_owner_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [CntW-1:0]       cnt_inc;
  logic                  timeout_hit;
  logic                  gnt_valid;
  logic                  gnt_idx;

  ptw_rr_arbiter u_rr_arbiter (
    .req        ({req1, req0}),
    .last_owner (last_owner_q),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    err_d        = err_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    // Saturate rather than wrap so a disabled timeout can never alias a limit.
    cnt_inc      = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
    timeout_hit  = (TIMEOUT != 0) && (cnt_inc == CntLimit);

    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          owner_d = gnt_idx;
          addr_d  = gnt_idx ? addr1 : addr0;
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        // A response landing on the timeout cycle still counts as success.
        if (mem_resp) begin
          data_d  = mem_data;
          err_d   = 1'b0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_inc;
          if (timeout_hit) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StResp: begin
        last_owner_d = owner_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      err_q        <= err_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    mem_req       = (state_q == StWait);
    mem_addr      = addr_q;
    busy          = (state_q != StIdle);
    owner         = owner_q;
    resp0         = (state_q == StResp) && !owner_q;
    resp1         = (state_q == StResp) && owner_q;
    data0         = resp0 ? data_q : '0;
    data1         = resp1 ? data_q : '0;
    err0          = resp0 && err_q;
    err1          = resp1 && err_q;
    timeout_pulse = (state_q == StResp) && err_q;
  end

endmodule
